// File: rtl/cd_time_setter.sv
// cd_time_setter: button-driven hh:mm:ss editor for the countdown timer.
//
// A rising edge on btn_set enters EDIT; btn_next cycles the selected field
// (SS -> MM -> HH); btn_up / btn_down step the selected field with per-field
// wrap-around and no carry into neighbouring fields. A second btn_set edge
// commits: the FSM passes through LOAD for one cycle, and at the end of that
// cycle tar_sec is loaded and init_en pulses for one clock.
//
// Optional feature (macro CD_SETTER_AUTOREPEAT_EN): holding btn_up or btn_down
// alone in EDIT steps once on the edge, once after REPEAT_DELAY cycles, then
// every REPEAT_RATE cycles until release.
//
// Ports:
//   clk        system clock, posedge
//   rst        synchronous active-high reset
//   btn_set    debounced level, edge enters / commits edit
//   btn_next   debounced level, edge selects next field
//   btn_up     debounced level, edge increments selected field
//   btn_down   debounced level, edge decrements selected field
//   tar_sec    committed target in seconds (hh*3600 + mm*60 + ss)
//   init_en    one-cycle load strobe, coincident with a new tar_sec
//   editing    high while in EDIT
//   field_sel  0 = SS, 1 = MM, 2 = HH
//   hh/mm/ss   current edit registers for the display
module cd_time_setter #(
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_set,
    input  logic        btn_next,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [16:0] tar_sec,
    output logic        init_en,
    output logic        editing,
    output logic [1:0]  field_sel,
    output logic [4:0]  hh,
    output logic [5:0]  mm,
    output logic [5:0]  ss
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EDIT = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [1:0] FLD_SS = 2'd0;
    localparam logic [1:0] FLD_MM = 2'd1;
    localparam logic [1:0] FLD_HH = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        set_prev, next_prev, up_prev, down_prev;
    logic        set_e, next_e, up_e, down_e;
    logic        step_up, step_dn;
    logic [16:0] tar_sec_d;
    logic        init_en_d, editing_d;
    logic [1:0]  field_sel_d;
    logic [4:0]  hh_d;
    logic [5:0]  mm_d, ss_d;

`ifdef CD_SETTER_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(RPT_MAX + 1);

    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_armed_q, rpt_armed_d;
    logic             rpt_fire;
`endif

    // Rising edges from the registered previous levels.
    assign set_e  = btn_set  & ~set_prev;
    assign next_e = btn_next & ~next_prev;
    assign up_e   = btn_up   & ~up_prev;
    assign down_e = btn_down & ~down_prev;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        tar_sec_d   = tar_sec;
        init_en_d   = 1'b0;
        editing_d   = 1'b0;
        field_sel_d = field_sel;
        hh_d        = hh;
        mm_d        = mm;
        ss_d        = ss;
        step_up     = up_e & ~down_e;
        step_dn     = down_e & ~up_e;

`ifdef CD_SETTER_AUTOREPEAT_EN
        // Repeat timer runs only while exactly one of up/down is held in EDIT.
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b0;
        rpt_fire    = 1'b0;
        if ((state_q == ST_EDIT) && (btn_up ^ btn_down) && !set_e) begin
            if (up_e | down_e) begin
                rpt_cnt_d = '0;
            end else if (!rpt_armed_q) begin
                if (rpt_cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                    rpt_fire    = 1'b1;
                    rpt_armed_d = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                end
            end else begin
                rpt_armed_d = 1'b1;
                if (rpt_cnt_q == CNT_W'(REPEAT_RATE - 1)) begin
                    rpt_fire = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                end
            end
        end
        step_up = step_up | (rpt_fire & btn_up);
        step_dn = step_dn | (rpt_fire & btn_down);
`endif

        case (state_q)
            ST_IDLE: begin
                if (set_e) begin
                    state_d     = ST_EDIT;
                    editing_d   = 1'b1;
                    field_sel_d = FLD_SS;
                end
            end
            ST_EDIT: begin
                if (set_e) begin
                    // Commit wins; same-cycle steps and field moves are dropped.
                    state_d = ST_LOAD;
                end else begin
                    editing_d = 1'b1;
                    case (field_sel)
                        FLD_SS: begin
                            if (step_up)      ss_d = (ss == 6'd59) ? 6'd0  : ss + 6'd1;
                            else if (step_dn) ss_d = (ss == 6'd0)  ? 6'd59 : ss - 6'd1;
                        end
                        FLD_MM: begin
                            if (step_up)      mm_d = (mm == 6'd59) ? 6'd0  : mm + 6'd1;
                            else if (step_dn) mm_d = (mm == 6'd0)  ? 6'd59 : mm - 6'd1;
                        end
                        FLD_HH: begin
                            if (step_up)      hh_d = (hh == 5'd23) ? 5'd0  : hh + 5'd1;
                            else if (step_dn) hh_d = (hh == 5'd0)  ? 5'd23 : hh - 5'd1;
                        end
                        default: ;
                    endcase
                    // Field advances after the step lands on the old field.
                    if (next_e) begin
                        field_sel_d = (field_sel == FLD_HH) ? FLD_SS : field_sel + 2'd1;
                    end
                end
            end
            ST_LOAD: begin
                state_d   = ST_IDLE;
                tar_sec_d = 17'(hh) * 17'd3600 + 17'(mm) * 17'd60 + 17'(ss);
                init_en_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, edge-detect and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            set_prev  <= 1'b0;
            next_prev <= 1'b0;
            up_prev   <= 1'b0;
            down_prev <= 1'b0;
            tar_sec   <= '0;
            init_en   <= 1'b0;
            editing   <= 1'b0;
            field_sel <= FLD_SS;
            hh        <= '0;
            mm        <= '0;
            ss        <= '0;
        end else begin
            state_q   <= state_d;
            set_prev  <= btn_set;
            next_prev <= btn_next;
            up_prev   <= btn_up;
            down_prev <= btn_down;
            tar_sec   <= tar_sec_d;
            init_en   <= init_en_d;
            editing   <= editing_d;
            field_sel <= field_sel_d;
            hh        <= hh_d;
            mm        <= mm_d;
            ss        <= ss_d;
        end
    end

`ifdef CD_SETTER_AUTOREPEAT_EN
    // Auto-repeat timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`endif

endmodule

// File: doc/cd_time_setter.md
CD_TIME_SETTER -- requirements
Module: cd_time_setter

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 50_000_000, meaning clk cycles an up/down button is held before auto-repeat starts.
REQ-002 SHALL have parameter REPEAT_RATE, default 10_000_000, meaning clk cycles between auto-repeat steps.
REQ-003 clk  input  1  system clock (100 MHz); all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_set  input  1  debounced level; rising edge enters or commits edit.
REQ-006 btn_next  input  1  debounced level; rising edge selects next field.
REQ-007 btn_up  input  1  debounced level; rising edge increments the selected field.
REQ-008 btn_down  input  1  debounced level; rising edge decrements the selected field.
REQ-009 tar_sec  output  17  committed target in seconds, hh*3600+mm*60+ss.
REQ-010 init_en  output  1  one-cycle load strobe to the countdown block.
REQ-011 editing  output  1  high while in EDIT.
REQ-012 field_sel  output  2  0=SS, 1=MM, 2=HH; 3 is never driven.
REQ-013 hh/mm/ss  output  5/6/6  current edit registers, for the display.

Function
REQ-014 SHALL detect button rising edges internally from a registered previous level; a level held high produces exactly one edge.
REQ-015 SHALL implement FSM IDLE, EDIT, LOAD; IDLE->EDIT on btn_set edge with field_sel<=0; EDIT->LOAD on btn_set edge; LOAD->IDLE unconditionally after one cycle.
REQ-016 In EDIT, a btn_next edge SHALL advance field_sel SS->MM->HH->SS.
REQ-017 In EDIT, a btn_up edge SHALL increment the selected field with wrap-around: ss/mm 59->0, hh 23->0; carries SHALL NOT propagate to other fields.
REQ-018 In EDIT, a btn_down edge SHALL decrement the selected field with wrap-around: ss/mm 0->59, hh 0->23.
REQ-019 Simultaneous up and down edges SHALL leave the field unchanged.
REQ-020 Simultaneous next and up/down edges SHALL apply the step to the currently selected field, then advance field_sel.
REQ-021 A btn_set edge in EDIT SHALL take priority, and same-cycle up/down/next SHALL be ignored.
REQ-022 In LOAD, tar_sec SHALL be registered and init_en SHALL be 1 for exactly that cycle; tar_sec is valid in the same cycle as init_en and holds until the next LOAD.
REQ-023 00:00:00 SHALL be committed normally (tar_sec=0, init_en pulses).
REQ-024 hh/mm/ss SHALL retain their values across LOAD and IDLE; the next EDIT starts from them.
REQ-025 In IDLE and LOAD, up/down/next SHALL be ignored.
REQ-026 Maximum tar_sec SHALL be 86399, which fits 17 bits with no overflow.

Reset
REQ-027 rst SHALL force state=IDLE, hh=mm=ss=0, field_sel=0, tar_sec=0, init_en=0, editing=0, edge registers=0, repeat counters=0.
REQ-028 rst asserted during EDIT or LOAD SHALL discard the edit, and init_en SHALL NOT pulse.

Configuration
REQ-029 Macro CD_SETTER_AUTOREPEAT_EN: when defined, holding btn_up or btn_down alone in EDIT SHALL produce one step on the edge, one step after REPEAT_DELAY cycles, then one step every REPEAT_RATE cycles until release; when undefined, only edges step and no repeat counters exist.
REQ-030 Under auto-repeat, releasing the button, pressing both buttons, or leaving EDIT SHALL clear the repeat counter.

Verification
REQ-031 rst, then set edge, up x3, next, up x2, next, down x1, set edge -> hh=23, mm=2, ss=3, one-cycle init_en, tar_sec=82923.
REQ-032 EDIT ss=59, up edge -> ss=0, mm unchanged; hh=0, down edge -> hh=23.
REQ-033 Up and down rise in the same cycle with mm=10 -> mm stays 10.
REQ-034 rst asserted in the LOAD cycle -> init_en=0, tar_sec=0, state IDLE.
REQ-035 With CD_SETTER_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_RATE=4, up held 22 cycles from ss=0 -> ss=4; macro undefined -> ss=1.
REQ-036 Set edge, set edge with no edits after reset -> tar_sec=0 and exactly one init_en pulse.
